// File: rtl/mc_line_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_line_responder_pkg
//  Description : Shared widths, FSM state encoding and default latencies for
//                the memory-controller line responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_line_responder_pkg;

    localparam int LINE_W         = 256;
    localparam int MC_ADDR_W      = 31;
    localparam int CNT_W          = 4;
    localparam int DEF_RD_LATENCY = 4;
    localparam int DEF_WR_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2,
        DONE    = 2'd3
    } mc_state_e;

    // Latency N completes N edges after acceptance, so the counter starts at N-1.
    function automatic logic [CNT_W-1:0] lat_to_count(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_line_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_line_responder_if
//  Description : Arbiter <-> memory-controller line interface. The arbiter
//                holds a level strobe until the matching completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mc_line_responder_if;
    import mc_line_responder_pkg::*;

    logic [LINE_W-1:0]    data_wr;
    logic [MC_ADDR_W-1:0] data_addr;
    logic                 data_rden;
    logic                 data_wren;
    logic [LINE_W-1:0]    data_rd;
    logic                 mc_rd_valid;
    logic                 mc_wr_rdy;
    logic                 mc_rd_rdy;
    logic                 proto_err;

    // Arbiter side
    modport master (
        output data_wr, data_addr, data_rden, data_wren,
        input  data_rd, mc_rd_valid, mc_wr_rdy, mc_rd_rdy, proto_err
    );

    // Memory-controller side
    modport slave (
        input  data_wr, data_addr, data_rden, data_wren,
        output data_rd, mc_rd_valid, mc_wr_rdy, mc_rd_rdy, proto_err
    );

endinterface
`default_nettype wire

// File: rtl/mc_line_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : mc_line_ram
//  Description : Single-port 2^ADDR_BITS x DATA_W synchronous RAM with a
//                registered read (read-first) and a write enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_line_ram
    import mc_line_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_W    = LINE_W
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Plain registered array access with no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mc_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mc_line_responder
//  Description : On-chip stand-in for the DDR2 controller. Services one line
//                read or write at a time with programmable latencies and
//                single-cycle completion pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_line_responder
    import mc_line_responder_pkg::*;
#(
    parameter int ADDR_BITS  = 10,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int WR_LATENCY = DEF_WR_LATENCY
) (
    input  logic                clk,
    input  logic                reset,
    mc_line_responder_if.slave  mc
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_WR_WAIT = WR_WAIT;
    localparam logic [1:0] S_RD_WAIT = RD_WAIT;
    localparam logic [1:0] S_DONE    = DONE;

    localparam logic [CNT_W-1:0] c_WR_CNT = lat_to_count(WR_LATENCY);
    localparam logic [CNT_W-1:0] c_RD_CNT = lat_to_count(RD_LATENCY);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_count;
    logic [ADDR_BITS-1:0] r_idx;
    logic [LINE_W-1:0]    r_wdata;
    logic [LINE_W-1:0]    r_data_rd;
    logic                 r_rd_valid;
    logic                 r_wr_rdy;
    logic                 r_rd_rdy;
    logic                 r_proto_err;

    logic                 w_in_idle;
    logic                 w_accept_wr;
    logic                 w_accept_rd;
    logic                 w_cnt_zero;
    logic                 w_ram_we;
    logic [ADDR_BITS-1:0] w_idx_in;
    logic [ADDR_BITS-1:0] w_ram_addr;
    logic [LINE_W-1:0]    w_ram_q;
    logic                 w_unused_addr_hi;

    // Upper address bits alias onto the array and are deliberately ignored.
    assign w_idx_in         = mc.data_addr[ADDR_BITS-1:0];
    assign w_unused_addr_hi = ^mc.data_addr[MC_ADDR_W-1:ADDR_BITS];

    // Write has priority when both strobes are seen at acceptance.
    assign w_in_idle   = (r_state == S_IDLE);
    assign w_accept_wr = w_in_idle && mc.data_wren;
    assign w_accept_rd = w_in_idle && !mc.data_wren && mc.data_rden;
    assign w_cnt_zero  = (r_count == '0);

    // The array is written only at write completion, so a reset during
    // WR_WAIT drops the pending write.
    assign w_ram_we   = (r_state == S_WR_WAIT) && w_cnt_zero;

    // In IDLE the live address drives the RAM so a read is issued on the
    // acceptance edge; afterwards the latched index keeps it stable.
    assign w_ram_addr = w_in_idle ? w_idx_in : r_idx;

    mc_line_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (LINE_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    // Transaction latches: captured at acceptance and ignored thereafter.
    always_ff @(posedge clk) begin
        if (w_accept_wr || w_accept_rd) begin
            r_idx <= w_idx_in;
        end
        if (w_accept_wr) begin
            r_wdata <= mc.data_wr;
        end
    end

    // Control FSM: accept, count down the latency, pulse, wait for strobe drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_data_rd   <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_rdy    <= 1'b0;
            r_rd_rdy    <= 1'b1;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mc.data_wren) begin
                        r_count  <= c_WR_CNT;
                        r_state  <= S_WR_WAIT;
                        r_rd_rdy <= 1'b0;
                        if (mc.data_rden) begin
                            r_proto_err <= 1'b1;
                        end
                    end else if (mc.data_rden) begin
                        r_count  <= c_RD_CNT;
                        r_state  <= S_RD_WAIT;
                        r_rd_rdy <= 1'b0;
                    end
                end
                S_WR_WAIT: begin
                    if (w_cnt_zero) begin
                        r_wr_rdy <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (w_cnt_zero) begin
                        r_data_rd  <= w_ram_q;
                        r_rd_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_DONE: begin
                    // A strobe still high here is the arbiter's late drop,
                    // not a new request.
                    r_rd_valid <= 1'b0;
                    r_wr_rdy   <= 1'b0;
                    if (!mc.data_rden && !mc.data_wren) begin
                        r_state  <= S_IDLE;
                        r_rd_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_rd_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign mc.data_rd     = r_data_rd;
    assign mc.mc_rd_valid = r_rd_valid;
    assign mc.mc_wr_rdy   = r_wr_rdy;
    assign mc.mc_rd_rdy   = r_rd_rdy;
    assign mc.proto_err   = r_proto_err;

endmodule
`default_nettype wire
